cpu_ctrl_fsm: RTL
=================

// Module: cpu_ctrl_fsm
// PURPOSE
//   Parametrised successor of the datapath controller FSM. Decodes opcode/op and sequences the
//   datapath (register file, A/B/C regs, shifter/ALU, status) plus a data-memory port.
//   Latches the instruction on the start handshake, so s need not be held.
//   Adds MVN/AND, LDR/STR with configurable memory wait states, HALT, and illegal-opcode reporting.
// PARAMETERS
//   MEM_EN    1  1: decode LDR/STR; 0: opcodes 011/100 treated as illegal
//   MEM_WAIT  1  extra MEM_RD cycles before LDR writeback, legal range 0..15
// PORTS
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous, active-high; state -> WAIT on next clk edge
//   s         in   1  start request, sampled only in WAIT
//   opcode    in   3  instruction opcode, latched when s && w
//   op        in   2  sub-op / ALU op, latched when s && w
//   w         out  1  1 only in WAIT (ready for start)
//   done      out  1  1-cycle pulse in final state of every legal instruction
//   err       out  1  1-cycle pulse in ILLEGAL state
//   nsel      out  2  regfile select: 00 Rm, 01 Rd, 10 Rn
//   vsel      out  2  writeback source: 00 C, 10 sximm8, 11 mdata
//   loada, loadb, loadc, loads, write, asel, bsel, load_addr   out  1 each
//   mem_cmd   out  2  00 NONE, 01 READ, 10 WRITE
// BEHAVIOUR
//   - Moore outputs, decoded from state + latched opcode/op only.
//   - Output defaults in every state unless listed: all loads/write/done/err = 0,
//     nsel = 00, vsel = 00, asel = bsel = 0, mem_cmd = 00.
//   - After the reset edge: state WAIT, w = 1, all other outputs at defaults; mid-instruction reset aborts.
//   - s is ignored outside WAIT. opcode/op changes after latching have no effect.
//   - Wait counter: 4 bits, loaded with MEM_WAIT on entry to MEM_RD, decremented there.
//   - Start (WAIT, s=1) goes to the first state of the sequence below; bracketed states are listed in order.
//   - 110/10 MOV imm: IMM [nsel=10, vsel=10, write, done] -> WAIT.
//   - 110/00 MOV reg: GET_B [nsel=00, loadb], PASS [asel=1, loadc], WB [nsel=01, vsel=00, write, done].
//   - 101/00 ADD, 101/10 AND: GET_A [nsel=10, loada], GET_B, ALU [loadc], WB.
//   - 101/01 CMP: GET_A, GET_B, ALU [loads, done] -> WAIT. No loadc and no writeback.
//   - 101/11 MVN: GET_B, ALU [loadc], WB. The A read is skipped.
//   - 011/00 LDR (MEM_EN): GET_A, ADDR [bsel=1, loadc], LD_ADDR [load_addr], MEM_RD x MEM_WAIT
//     [mem_cmd=01], WB_MEM [mem_cmd=01, nsel=01, vsel=11, write, done].
//     With MEM_WAIT = 0, MEM_RD is skipped.
//   - 100/00 STR (MEM_EN): GET_A, ADDR, LD_ADDR, GET_B_RD [nsel=01, loadb],
//     PASS [asel=1, loadc], MEM_WR [mem_cmd=10, done].
//   - 111/xx HALT: HALT state, w = 0, exited only by reset.
//   - Any other opcode/op (incl. LDR/STR when MEM_EN = 0): ILLEGAL [err] -> WAIT.
//   - Cycles from start edge to return to WAIT: MOV imm 1, MOV reg 3, CMP 3, MVN 3, ADD/AND 4,
//     LDR 4+MEM_WAIT, STR 6, illegal 1.
//   - Start in the same cycle as a final state: not possible, because w = 0 there.
//     The next instruction can start in the WAIT cycle that follows.
//   - Unreachable state encodings return to WAIT on the next edge.
// TESTING
//   - Reset held 2 cycles mid-ADD (in ALU) -> WAIT next edge, w = 1, write never asserted, loadc = 0 after reset.
//   - s=1 for 1 cycle, 110/10 -> next cycle nsel=10, vsel=10, write=1, done=1; then w=1.
//   - s=1 for 1 cycle, 101/01 CMP, opcode changed to 110 after latch
//     -> loada, loadb, loads sequence; no write; done in cycle 3.
//   - MEM_WAIT=3, LDR -> mem_cmd=01 for 4 cycles; write=1 with vsel=11, nsel=01 in cycle 7; w=1 in cycle 8.
//   - MEM_EN=0, opcode 100 -> err=1 for exactly 1 cycle, no loads, back to WAIT.
//   - HALT then s pulses for 10 cycles -> w stays 0, all outputs default; reset -> w=1.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Datapath controller FSM: latches opcode/op on start and sequences the regfile, ALU,
// status register and a data-memory port with configurable read wait states.
//
// state      | meaning
// WAIT       | idle, w=1, accepts start
// IMM        | MOV imm writeback
// GET_A      | read Rn into A
// GET_B      | read Rm into B
// PASS       | B passed through to C (asel)
// ALU        | ALU result into C, or status only for CMP
// WB         | C written back to Rd
// ADDR       | address = A + sximm (bsel) into C
// LD_ADDR    | C into address register
// MEM_RD     | memory read wait states
// WB_MEM     | mdata written back to Rd
// GET_B_RD   | read Rd into B for store data
// MEM_WR     | memory write
// HALT       | stopped until reset
// ILLEGAL    | err pulse for an undecodable instruction
module cpu_ctrl_fsm #(
  parameter int MEM_EN   = 1,
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic       done,
  output logic       err,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic       load_addr,
  output logic [1:0] mem_cmd
);

  typedef enum logic [3:0] {
    S_WAIT     = 4'd0,
    S_IMM      = 4'd1,
    S_GET_A    = 4'd2,
    S_GET_B    = 4'd3,
    S_PASS     = 4'd4,
    S_ALU      = 4'd5,
    S_WB       = 4'd6,
    S_ADDR     = 4'd7,
    S_LD_ADDR  = 4'd8,
    S_MEM_RD   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_GET_B_RD = 4'd11,
    S_MEM_WR   = 4'd12,
    S_HALT     = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [3:0] WAIT_INIT = MEM_WAIT[3:0];

  state_t     state, state_next;
  logic [2:0] ir_opc;
  logic [1:0] ir_op;
  logic [3:0] wait_cnt;
  logic       is_movreg, is_cmp, is_str;

  // First state of each sequence, decoded straight from the inputs at the start edge.
  function automatic state_t first_state(input logic [2:0] opc, input logic [1:0] o);
    state_t f;
    f = S_ILLEGAL;
    case (opc)
      3'b110: if (o == 2'b10) f = S_IMM; else if (o == 2'b00) f = S_GET_B;
      3'b101: f = (o == 2'b11) ? S_GET_B : S_GET_A;
      3'b011,
      3'b100: if ((MEM_EN != 0) && (o == 2'b00)) f = S_GET_A;
      3'b111: f = S_HALT;
      default: f = S_ILLEGAL;
    endcase
    return f;
  endfunction

  assign is_movreg = (ir_opc == 3'b110);
  assign is_cmp    = (ir_opc == 3'b101) && (ir_op == 2'b01);
  assign is_str    = (ir_opc == 3'b100);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT;
      ir_opc   <= 3'b000;
      ir_op    <= 2'b00;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (state == S_WAIT && s) begin
        ir_opc <= opcode;
        ir_op  <= op;
      end
      if (state_next == S_MEM_RD && state != S_MEM_RD)
        wait_cnt <= WAIT_INIT;
      else if (state == S_MEM_RD)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_next = S_WAIT;
    case (state)
      S_WAIT:     state_next = s ? first_state(opcode, op) : S_WAIT;
      S_IMM:      state_next = S_WAIT;
      S_GET_A:    state_next = (ir_opc == 3'b011 || is_str) ? S_ADDR : S_GET_B;
      S_GET_B:    state_next = is_movreg ? S_PASS : S_ALU;
      S_PASS:     state_next = is_str ? S_MEM_WR : S_WB;
      S_ALU:      state_next = is_cmp ? S_WAIT : S_WB;
      S_WB:       state_next = S_WAIT;
      S_ADDR:     state_next = S_LD_ADDR;
      S_LD_ADDR:  state_next = is_str ? S_GET_B_RD :
                               (WAIT_INIT == 4'd0) ? S_WB_MEM : S_MEM_RD;
      // terminal count: leave on the last wait cycle
      S_MEM_RD:   state_next = (wait_cnt <= 4'd1) ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM:   state_next = S_WAIT;
      S_GET_B_RD: state_next = S_PASS;
      S_MEM_WR:   state_next = S_WAIT;
      S_HALT:     state_next = S_HALT;
      S_ILLEGAL:  state_next = S_WAIT;
      default:    state_next = S_WAIT;
    endcase
  end

  always_comb begin
    w         = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    nsel      = 2'b00;
    vsel      = 2'b00;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    case (state)
      S_WAIT:     w = 1'b1;
      S_IMM:      begin nsel = 2'b10; vsel = 2'b10; write = 1'b1; done = 1'b1; end
      S_GET_A:    begin nsel = 2'b10; loada = 1'b1; end
      S_GET_B:    loadb = 1'b1;
      S_PASS:     begin asel = 1'b1; loadc = 1'b1; end
      S_ALU:      if (is_cmp) begin loads = 1'b1; done = 1'b1; end else loadc = 1'b1;
      S_WB:       begin nsel = 2'b01; write = 1'b1; done = 1'b1; end
      S_ADDR:     begin bsel = 1'b1; loadc = 1'b1; end
      S_LD_ADDR:  load_addr = 1'b1;
      S_MEM_RD:   mem_cmd = 2'b01;
      S_WB_MEM:   begin mem_cmd = 2'b01; nsel = 2'b01; vsel = 2'b11; write = 1'b1; done = 1'b1; end
      S_GET_B_RD: begin nsel = 2'b01; loadb = 1'b1; end
      S_MEM_WR:   begin mem_cmd = 2'b10; done = 1'b1; end
      S_ILLEGAL:  err = 1'b1;
      default:    w = 1'b0;
    endcase
  end

endmodule
